// File: rtl/sms4_round_ctrl.sv
// ---------------------------------------------------------------------------
// sms4_round_ctrl
//
// Round sequencer for the SMS4 block cipher. It loads one 128-bit block into
// the four-word state X0..X3 and then runs one cipher round per clock for
// NROUNDS rounds. Each round uses the external T-transform datapath and the
// external round-key storage. When the rounds are complete, it presents the
// reverse-ordered final state {X3,X2,X1,X0} under a valid/ready handshake.
//
// Words are packed MSB-first: X0 is the most significant word of din.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        load request, sampled only while idle
//   decrypt      key order for the block being loaded (1 = reverse order)
//   din          input block {X0,X1,X2,X3}
//   rk_addr      round-key index presented to key storage (0 when not running)
//   rk_in        round key for rk_addr, returned combinationally
//   t_in         X1^X2^X3^rk_in, sent to the T-transform
//   t_out        T(t_in), returned combinationally
//   busy         high while a block is being processed or held for output
//   dout         result block {X3,X2,X1,X0}
//   dout_valid   result available
//   dout_ready   consumer accepts the result
// ---------------------------------------------------------------------------
module sms4_round_ctrl #(
   parameter  int BWIDTH  = 32,
   parameter  int NROUNDS = 32,
   localparam int RW      = $clog2(NROUNDS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  decrypt,
   input  logic [4*BWIDTH-1:0]   din,
   output logic [RW-1:0]         rk_addr,
   input  logic [BWIDTH-1:0]     rk_in,
   output logic [BWIDTH-1:0]     t_in,
   input  logic [BWIDTH-1:0]     t_out,
   output logic                  busy,
   output logic [4*BWIDTH-1:0]   dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [RW-1:0] LAST_R = RW'(NROUNDS - 1);

   state_t              state_q, state_d;
   logic [BWIDTH-1:0]   x0_q, x0_d;
   logic [BWIDTH-1:0]   x1_q, x1_d;
   logic [BWIDTH-1:0]   x2_q, x2_d;
   logic [BWIDTH-1:0]   x3_q, x3_d;
   logic [RW-1:0]       r_q, r_d;
   logic                mode_q, mode_d;

   // State register. Reset clears the data words as well, so that dout reads
   // zero and an abandoned block leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x0_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         x3_q    <= '0;
         r_q     <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         x3_q    <= x3_d;
         r_q     <= r_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic. The state words move only while loading or running,
   // so the result stays stable in DONE for as long as the consumer stalls.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      x3_d    = x3_q;
      r_d     = r_q;
      mode_d  = mode_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x0_d    = din[4*BWIDTH-1 -: BWIDTH];
               x1_d    = din[3*BWIDTH-1 -: BWIDTH];
               x2_d    = din[2*BWIDTH-1 -: BWIDTH];
               x3_d    = din[BWIDTH-1   -: BWIDTH];
               mode_d  = decrypt;
               r_d     = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            // One SMS4 round: shift the window and append X0 ^ T(...).
            x0_d = x1_q;
            x1_d = x2_q;
            x2_d = x3_q;
            x3_d = x0_q ^ t_out;
            if (r_q == LAST_R) begin
               r_d     = '0;
               state_d = DONE;
            end else begin
               r_d = r_q + RW'(1);
            end
         end

         DONE: begin
            if (dout_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Round-key address. Decryption walks the schedule backwards. The address
   // is parked at 0 outside RUN.
   always_comb begin
      rk_addr = '0;
      if (state_q == RUN) begin
         rk_addr = mode_q ? (LAST_R - r_q) : r_q;
      end
   end

   assign t_in       = x1_q ^ x2_q ^ x3_q ^ rk_in;
   assign busy       = (state_q != IDLE);
   assign dout_valid = (state_q == DONE);
   assign dout       = {x3_q, x2_q, x1_q, x0_q};

endmodule

// File: tb/tb_sms4_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sms4_round_ctrl
//
// Testbench for sms4_round_ctrl.
//
// The bench supplies the round-key storage and the T-transform to the DUT
// combinationally. It computes the key schedule and the full cipher itself
// from the SMS4 definition. It checks:
//   - the standard known-answer tests,
//   - latency, rk_addr order, backpressure, busy lockout,
//   - reset in the middle of a block,
//   - back-to-back throughput,
//   - random keys and blocks.
// ---------------------------------------------------------------------------
module tb_sms4_round_ctrl;

   localparam int BWIDTH  = 32;
   localparam int NROUNDS = 32;

   localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KAT_PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          start      = 1'b0;
   logic          decrypt    = 1'b0;
   logic          dout_ready = 1'b0;
   logic [127:0]  din        = '0;
   logic [4:0]    rk_addr;
   logic [31:0]   rk_in;
   logic [31:0]   t_in;
   logic [31:0]   t_out;
   logic          busy;
   logic [127:0]  dout;
   logic          dout_valid;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0]  rkTab [0:31];

   // SMS4 S-box, one row of sixteen bytes per entry, leftmost byte first.
   logic [127:0] sboxRows [0:15] = '{
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   always #5 clk = ~clk;

   sms4_round_ctrl #(
      .BWIDTH  (BWIDTH),
      .NROUNDS (NROUNDS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .decrypt    (decrypt),
      .din        (din),
      .rk_addr    (rk_addr),
      .rk_in      (rk_in),
      .t_in       (t_in),
      .t_out      (t_out),
      .busy       (busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   // ------------------------------------------------------------------------
   // Cipher primitives used by the external datapath and the reference model
   // ------------------------------------------------------------------------
   function automatic logic [7:0] sboxByte(input logic [7:0] a);
      logic [127:0] row;
      int           pos;
      row = sboxRows[a[7:4]];
      pos = 8 * (15 - int'(a[3:0]));
      return row[pos +: 8];
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      return {sboxByte(a[31:24]), sboxByte(a[23:16]), sboxByte(a[15:8]), sboxByte(a[7:0])};
   endfunction

   function automatic logic [31:0] tData(input logic [31:0] x);
      logic [31:0] b;
      b = tau(x);
      return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
   endfunction

   function automatic logic [31:0] tKey(input logic [31:0] x);
      logic [31:0] b;
      b = tau(x);
      return b ^ rol(b, 13) ^ rol(b, 23);
   endfunction

   // External key storage and T-datapath, both combinational
   assign rk_in = rkTab[rk_addr];
   always_comb t_out = tData(t_in);

   // Standard SMS4 key expansion into rkTab
   task automatic setKey(input logic [127:0] key);
      logic [31:0] k [0:35];
      logic [31:0] fk [0:3];
      logic [31:0] ck;
      fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
      k[0] = key[127:96] ^ fk[0];
      k[1] = key[95:64]  ^ fk[1];
      k[2] = key[63:32]  ^ fk[2];
      k[3] = key[31:0]   ^ fk[3];
      for (int i = 0; i < 32; i++) begin
         ck = '0;
         for (int j = 0; j < 4; j++) begin
            ck = {ck[23:0], 8'((4 * i + j) * 7)};
         end
         k[i+4]   = k[i] ^ tKey(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
         rkTab[i] = k[i+4];
      end
   endtask

   // Full-block cipher over the current key schedule. The output is reversed.
   function automatic logic [127:0] sm4Model(input logic [127:0] blk, input logic dec);
      logic [31:0] x [0:35];
      x[0] = blk[127:96];
      x[1] = blk[95:64];
      x[2] = blk[63:32];
      x[3] = blk[31:0];
      for (int i = 0; i < 32; i++) begin
         x[i+4] = x[i] ^ tData(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rkTab[31-i] : rkTab[i]));
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic [127:0] randBlock();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Runs one block.
   //   - Checks the latency, the rk_addr order and the result.
   //   - Optionally pulses start at round lockRound (-1 means never).
   //   - Stalls the consumer for holdCycles cycles, then completes the handshake.
   task automatic applyStimulus(input logic [127:0] blk, input logic dec, input logic [127:0] expected,
                                input int lockRound, input int holdCycles, input string tag);
      int           cycles;
      int           idx;
      logic         gotValid;
      logic         stableOk;
      logic         quiet;
      logic [127:0] held;
      @(negedge clk);
      din        = blk;
      decrypt    = dec;
      start      = 1'b1;
      dout_ready = 1'b0;
      cycles     = 0;
      idx        = 0;
      gotValid   = 1'b0;
      while (!gotValid && cycles < 100) begin
         @(posedge clk);
         cycles++;
         #1;
         if (idx == lockRound) begin
            start   = 1'b1;
            din     = ~blk;
            decrypt = ~dec;
         end else begin
            start   = 1'b0;
            decrypt = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (dout_valid) begin
            gotValid = 1'b1;
         end else if (busy) begin
            checkOutput({tag, "_rk_addr"}, 128'(rk_addr), 128'(dec ? (31 - idx) : idx));
            idx++;
         end
      end
      start = 1'b0;
      checkOutput({tag, "_latency"}, 128'(cycles), 128'(33));
      checkOutput({tag, "_rounds"}, 128'(idx), 128'(32));
      checkOutput({tag, "_dout"}, dout, expected);

      held     = dout;
      stableOk = 1'b1;
      for (int h = 0; h < holdCycles; h++) begin
         @(posedge clk);
         #1;
         start = ((h % 2) == 0);
         din   = randBlock();
         @(negedge clk);
         if (!(dout_valid && busy && dout == held)) stableOk = 1'b0;
      end
      if (holdCycles > 0) checkOutput({tag, "_hold"}, 128'(stableOk), 128'(1));

      start      = 1'b0;
      dout_ready = 1'b1;
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_release"}, 128'({busy, dout_valid}), 128'(0));
      quiet = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (busy || dout_valid) quiet = 1'b0;
      end
      checkOutput({tag, "_quiet"}, 128'(quiet), 128'(1));
   endtask

   // Reset asserted during round 17, then a fresh encrypt KAT
   task automatic resetMidOp();
      @(negedge clk);
      din     = KAT_PT;
      decrypt = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      checkOutput("pre_rst_rk_addr", 128'(rk_addr), 128'(17));
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_ctrl", 128'({busy, dout_valid, rk_addr}), 128'(0));
      checkOutput("mid_rst_dout", dout, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(KAT_PT, 1'b0, KAT_CT, -1, 0, "post_rst");
   endtask

   // start and dout_ready both held high: one result every 34 cycles
   task automatic backToBack();
      int cyc;
      int lastCyc;
      int blocks;
      @(negedge clk);
      din        = KAT_PT;
      decrypt    = 1'b0;
      start      = 1'b1;
      dout_ready = 1'b1;
      cyc        = 0;
      lastCyc    = 0;
      blocks     = 0;
      while (blocks < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (dout_valid) begin
            if (blocks > 0) checkOutput("b2b_period", 128'(cyc - lastCyc), 128'(34));
            checkOutput("b2b_dout", dout, KAT_CT);
            lastCyc = cyc;
            blocks++;
         end
      end
      checkOutput("b2b_blocks", 128'(blocks), 128'(3));
      start = 1'b0;
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      @(negedge clk);
      checkOutput("b2b_idle", 128'({busy, dout_valid}), 128'(0));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] blk;
      logic [127:0] ct;
      logic         dec;

      setKey(KAT_KEY);
      #3;
      checkOutput("reset_ctrl", 128'({busy, dout_valid, rk_addr}), 128'(0));
      checkOutput("reset_dout", dout, 128'(0));
      checkOutput("reset_t_in", 128'(t_in), 128'(rkTab[0]));
      #9;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_no_start", 128'({busy, dout_valid}), 128'(0));

      applyStimulus(KAT_PT, 1'b0, KAT_CT, -1, 10, "enc_kat");
      applyStimulus(KAT_CT, 1'b1, KAT_PT, -1, 2, "dec_kat");
      applyStimulus(KAT_PT, 1'b0, KAT_CT, 5, 0, "lockout");
      resetMidOp();
      backToBack();

      for (int n = 0; n < 4; n++) begin
         setKey(randBlock());
         blk = randBlock();
         dec = 1'($urandom_range(0, 1));
         ct  = sm4Model(blk, dec);
         applyStimulus(blk, dec, ct, -1, int'($urandom_range(0, 3)), "rand");
         applyStimulus(ct, ~dec, blk, -1, 0, "rand_inv");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
